// File: rtl/bus_drive_decoder.sv
// Index-to-one-hot bus source driver with break-before-make gaps between different sources.
// Define BUS_SEL_CHECK_EN to add the sel_fb loopback compare and the sticky sel_err flag.
module bus_drive_decoder #(
    parameter int IDX_W      = 5,
    parameter int LEN_W      = 4,
    parameter int GAP_CYCLES = 1,
    localparam int N         = 2**IDX_W
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_idx,
    input  logic [LEN_W-1:0] req_len,
    output logic [N-1:0]     drive_out,
    output logic             busy,
    output logic             done
`ifdef BUS_SEL_CHECK_EN
    ,
    input  logic [IDX_W-1:0] sel_fb,
    output logic             sel_err
`endif
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, GAP, DRIVE} state_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic [LEN_W-1:0] cnt, cnt_n;
    logic [GAP_W-1:0] gap_cnt, gap_n;
    logic [N-1:0]     drive_n;
    logic             accept;

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE;
            idx_q     <= '0;
            cnt       <= '0;
            gap_cnt   <= '0;
            drive_out <= '0;
        end else begin
            state     <= state_n;
            idx_q     <= idx_n;
            cnt       <= cnt_n;
            gap_cnt   <= gap_n;
            drive_out <= drive_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx_q;
        cnt_n   = cnt;
        gap_n   = gap_cnt;
        accept  = req_valid && req_ready;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = DRIVE;
                    idx_n   = req_idx;
                    cnt_n   = req_len;
                end
            end
            DRIVE: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (accept) begin
                    idx_n = req_idx;
                    cnt_n = req_len;
                    // Only a change of source needs the bus released first.
                    if (req_idx == idx_q || GAP_CYCLES == 0) begin
                        state_n = DRIVE;
                    end else begin
                        state_n = GAP;
                        gap_n   = GAP_W'(GAP_CYCLES - 1);
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_n = DRIVE;
                end else begin
                    gap_n = gap_cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // drive_out is registered, so its next value follows the next state.
    always_comb begin
        done      = (state == DRIVE) && (cnt == '0);
        busy      = (state != IDLE);
        req_ready = (state == IDLE) || done;
        drive_n   = (state_n == DRIVE) ? (N'(1) << idx_n) : '0;
    end

`ifdef BUS_SEL_CHECK_EN
    always_ff @(posedge clk) begin
        if (clr) begin
            sel_err <= 1'b0;
        end else if (state == DRIVE && sel_fb != idx_q) begin
            sel_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_bus_drive_decoder.sv
// Scoreboard bench for bus_drive_decoder: directed per-cycle vectors, expected outputs queued, monitor compares.
// With BUS_SEL_CHECK_EN defined, an extra directed loopback-error sequence runs at the end.
module tb_bus_drive_decoder;

    typedef struct packed {
        logic        clr;
        logic        valid;
        logic [4:0]  idx;
        logic [3:0]  len;
        logic [31:0] drv;
        logic        done;
        logic        busy;
        logic        ready;
    } vec_t;

    typedef struct packed {
        logic [31:0] drv;
        logic        done;
        logic        busy;
        logic        ready;
    } obs_t;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_idx = '0;
    logic [3:0]  req_len = '0;
    logic [31:0] drive_out;
    logic        busy;
    logic        done;

    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;
    vec_t vecs[$];
    obs_t exp_q[$];

`ifdef BUS_SEL_CHECK_EN
    logic [4:0] sel_fb;
    logic       sel_err;
    logic       bad_fb = 1'b0;
    logic [4:0] enc;

    always_comb begin
        enc = '0;
        for (int i = 0; i < 32; i++) begin
            if (drive_out[i]) enc = 5'(i);
        end
        sel_fb = bad_fb ? enc + 5'd1 : enc;
    end
`endif

    bus_drive_decoder dut (
        .clk       (clk),
        .clr       (clr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_idx   (req_idx),
        .req_len   (req_len),
        .drive_out (drive_out),
        .busy      (busy),
        .done      (done)
`ifdef BUS_SEL_CHECK_EN
        ,
        .sel_fb    (sel_fb),
        .sel_err   (sel_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic addVec(input logic c, input logic v, input logic [4:0] i, input logic [3:0] l,
                          input logic [31:0] d, input logic dn, input logic b, input logic r);
        vecs.push_back('{c, v, i, l, d, dn, b, r});
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        clr       = v.clr;
        req_valid = v.valid;
        req_idx   = v.idx;
        req_len   = v.len;
        if (!v.clr) exp_q.push_back('{v.drv, v.done, v.busy, v.ready});
    endtask

    // Each row: inputs offered this cycle, and the outputs the DUT must show in this same cycle.
    task automatic buildVectors();
        addVec(1, 0, 0, 0, 32'h0, 0, 0, 0);
        addVec(1, 0, 0, 0, 32'h0, 0, 0, 0);
        addVec(0, 0, 0, 0, 32'h0, 0, 0, 1);
        // idx=5 len=2
        addVec(0, 1, 5, 2, 32'h0, 0, 0, 1);
        addVec(0, 0, 0, 0, 32'h0000_0020, 0, 1, 0);
        addVec(0, 0, 0, 0, 32'h0000_0020, 0, 1, 0);
        addVec(0, 0, 0, 0, 32'h0000_0020, 1, 1, 1);
        addVec(0, 0, 0, 0, 32'h0, 0, 0, 1);
        // idx=3 len=0, then idx=17 through one gap cycle
        addVec(0, 1, 3, 0, 32'h0, 0, 0, 1);
        addVec(0, 1, 17, 0, 32'h0000_0008, 1, 1, 1);
        addVec(0, 0, 0, 0, 32'h0, 0, 1, 0);
        addVec(0, 0, 0, 0, 32'h0002_0000, 1, 1, 1);
        // idx=31 len=1 extended seamlessly by idx=31 len=0
        addVec(0, 1, 31, 1, 32'h0, 0, 0, 1);
        addVec(0, 0, 0, 0, 32'h8000_0000, 0, 1, 0);
        addVec(0, 1, 31, 0, 32'h8000_0000, 1, 1, 1);
        addVec(0, 0, 0, 0, 32'h8000_0000, 1, 1, 1);
        // idx=9 len=7 interrupted by clr in its second cycle
        addVec(0, 1, 9, 7, 32'h0, 0, 0, 1);
        addVec(0, 0, 0, 0, 32'h0000_0200, 0, 1, 0);
        addVec(1, 0, 0, 0, 32'h0, 0, 0, 0);
        // idx=0 len=15: sixteen cycles
        addVec(0, 1, 0, 15, 32'h0, 0, 0, 1);
        for (int k = 0; k < 16; k++) begin
            addVec(0, 0, 0, 0, 32'h0000_0001, (k == 15), 1, (k == 15));
        end
        // valid held high: one acceptance per final cycle, same source chains seamlessly
        addVec(0, 1, 2, 1, 32'h0, 0, 0, 1);
        addVec(0, 1, 2, 1, 32'h0000_0004, 0, 1, 0);
        addVec(0, 1, 2, 1, 32'h0000_0004, 1, 1, 1);
        addVec(0, 1, 2, 1, 32'h0000_0004, 0, 1, 0);
        addVec(0, 1, 6, 0, 32'h0000_0004, 1, 1, 1);
        addVec(0, 1, 6, 0, 32'h0, 0, 1, 0);
        addVec(0, 0, 0, 0, 32'h0000_0040, 1, 1, 1);
        addVec(0, 0, 0, 0, 32'h0, 0, 0, 1);
    endtask

    // Monitor: compares every presented cycle against the head of the scoreboard.
    always @(negedge clk) begin
        if (mon_en && !clr) begin
            checkOutput("onehot", 64'($countones(drive_out) <= 1), 64'd1);
            if (exp_q.size() == 0) begin
                checkOutput("underflow", 64'd1, 64'd0);
            end else begin
                obs_t e;
                e = exp_q.pop_front();
                checkOutput("cycle", 64'({drive_out, done, busy, req_ready}),
                            64'({e.drv, e.done, e.busy, e.ready}));
            end
        end
    end

    initial begin
        buildVectors();
        mon_en = 1'b1;
        while (vecs.size() != 0) applyStimulus(vecs.pop_front());
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        checkOutput("drained", 64'(exp_q.size()), 64'd0);

`ifdef BUS_SEL_CHECK_EN
        @(posedge clk); #1; clr = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1; clr = 1'b0;
        @(negedge clk); checkOutput("sel_err_rst", 64'(sel_err), 64'd0);
        @(posedge clk); #1; req_valid = 1'b1; req_idx = 5'd12; req_len = 4'd2;
        @(posedge clk); #1; req_valid = 1'b0; bad_fb = 1'b1;
        @(posedge clk); #1; bad_fb = 1'b0;
        @(negedge clk); checkOutput("sel_err_set", 64'(sel_err), 64'd1);
        @(posedge clk); #1; @(posedge clk); #1;
        req_valid = 1'b1; req_idx = 5'd4; req_len = 4'd0;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1; @(posedge clk); #1;
        checkOutput("sel_err_hold", 64'(sel_err), 64'd1);
        clr = 1'b1;
        @(posedge clk); #1; clr = 1'b0;
        checkOutput("sel_err_clr", 64'(sel_err), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_drive_decoder.md
Name: bus_drive_decoder

Overview:
Index-to-one-hot bus source driver: the transmitting end of the bus-select path whose one-hot drive vector the 32-to-5 encoder consumes.
- Accepts a 5-bit source index plus a drive length over a valid/ready handshake.
- Asserts exactly one bit of a 32-bit registered drive vector for the requested number of cycles.
- Inserts a break-before-make gap whenever the driven source changes, so the shared bus never sees two drivers.

Parameters:
IDX_W, 5, width of source index.
N, 32, drive vector width; fixed at 2**IDX_W.
LEN_W, 4, width of the drive-length field; a burst lasts req_len+1 cycles (1..16).
GAP_CYCLES, 1, all-zero drive cycles inserted when switching between different sources; 0 is legal and means no gap.

Ports:
clk  input  1  rising-edge clock
clr  input  1  reset; synchronous, active-high
req_valid  input  1  request offered
req_ready  output  1  block can accept a request this cycle
req_idx  input  IDX_W  source to drive, 0..31
req_len  input  LEN_W  drive cycles minus one
drive_out  output  N  registered one-hot source enables (all-zero when idle or in gap)
busy  output  1  state is not IDLE
done  output  1  high during the final DRIVE cycle of a burst

Behaviour:
- Reset: clr high at a clock edge puts all state in IDLE after that edge:
  - drive_out=0, done=0, busy=0, counters=0, latched idx/len cleared.
  - Any request offered in the same cycle is dropped.
  - Reset mid-burst or mid-gap releases the bus on the very next cycle.
- Handshake:
  - Transfer occurs when req_valid && req_ready at a rising edge.
  - req_ready is combinational: high in IDLE, and high in the final DRIVE cycle (when done=1); low otherwise.
  - req_idx and req_len are sampled only at transfer.
- States: IDLE, GAP, DRIVE.
- IDLE:
  - drive_out=0.
  - On transfer: latch idx/len, go to DRIVE. drive_out = 1<<idx is visible on the cycle after the accepting edge (latency 1).
- DRIVE:
  - drive_out = 1<<idx_latched; the down-counter is loaded with len.
  - The state lasts len+1 cycles; done=1 on the cycle where the counter is 0.
  - Final cycle, no transfer: go to IDLE; drive_out=0 next cycle.
  - Final cycle, transfer with the same idx: remain in DRIVE with no zero cycle (seamless extension), reload the counter with the new len.
  - Final cycle, transfer with a different idx and GAP_CYCLES>0: go to GAP; drive_out=0 for exactly GAP_CYCLES cycles, then DRIVE with the new idx.
  - Final cycle, transfer with a different idx and GAP_CYCLES=0: switch directly to DRIVE with the new idx.
- GAP:
  - drive_out=0, busy=1, req_ready=0; the gap counter counts down to 0, then the state goes to DRIVE.
- Invariants: popcount(drive_out) <= 1 on every cycle; drive_out never changes directly from one nonzero value to a different nonzero value when GAP_CYCLES>0.
- Boundaries:
  - idx=0 drives bit 0; idx=31 drives bit 31.
  - req_len=15 gives 16 cycles.
  - req_len=0 gives a 1-cycle burst with done high in that same cycle.
  - req_valid held high continuously produces back-to-back bursts; one request is accepted per final cycle only.

Optional Feature:
Macro BUS_SEL_CHECK_EN enables a loopback check against the downstream encoder.
- Defined:
  - Adds input sel_fb (IDX_W), the encoder output for drive_out, and output sel_err (1).
  - On each DRIVE cycle, sel_fb != idx_latched sets sel_err.
  - sel_err is sticky and is cleared only by clr (reset value 0).
  - sel_fb is ignored in IDLE and GAP.
- Undefined: sel_fb and sel_err do not exist and no compare logic is built.

Test Plan:
1. clr for 2 cycles, then release -> drive_out=0, busy=0, done=0, req_ready=1.
2. IDLE, send idx=5, len=2 -> drive_out=0x00000020 for 3 cycles starting the cycle after acceptance; done high on the 3rd; then 0 and IDLE.
3. Burst on idx=3, len=0, with idx=17 offered during its done cycle, GAP_CYCLES=1 -> 0x00000008, then 0x00000000 for 1 cycle, then 0x00020000.
4. Same-idx chain: idx=31, len=1, then idx=31, len=0 offered on the final cycle -> 0x80000000 held for 3 consecutive cycles with no zero gap.
5. clr asserted during cycle 2 of an idx=9, len=7 burst -> drive_out=0 on the next cycle, state IDLE, req_ready=1.
6. With BUS_SEL_CHECK_EN, drive idx=12 while forcing sel_fb=13 for one cycle -> sel_err=1 and held through later correct bursts until clr.
